// File: rtl/rst_sequencer.sv
// Reset and clock-lock sequencer for the system clock domain: synchronises the board
// reset and PLL lock, then releases peripherals first and the core CORE_DELAY cycles later.
module rst_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int CORE_DELAY      = 16,
    parameter int SW_RST_CYC      = 64
) (
    input  logic       clk_sys,
    input  logic       rst_sys_n,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       rst_periph_n,
    output logic       rst_core_n,
    output logic [2:0] rst_state,
    output logic [1:0] rst_cause,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (LOCK_STABLE_CYC > CORE_DELAY) ? LOCK_STABLE_CYC : CORE_DELAY;
    localparam int MAX_CYC = (MAX_AB > SW_RST_CYC) ? MAX_AB : SW_RST_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYC - 1);

    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [2:0] {
        HOLD        = 3'd0,
        WAIT_LOCK   = 3'd1,
        LOCK_STABLE = 3'd2,
        PERIPH_ON   = 3'd3,
        RUN         = 3'd4,
        SW_RST      = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             cause_q, cause_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic                   rst_periph_n_q, rst_periph_n_d;
    logic                   rst_core_n_q, rst_core_n_d;
    logic                   rst_sync_n, lock_s, lock_lost;

    // Reset release shifts ones in behind the async clear; lock shifts the raw flag.
    always_comb begin
        rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];
    assign lock_s     = lock_sync_q[SYNC_STAGES-1];
    assign lock_lost  = !lock_s && (state_q inside {PERIPH_ON, RUN, SW_RST});

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cause_d    = cause_q;
        loss_cnt_d = loss_cnt_q;

        case (state_q)
            HOLD:        if (rst_sync_n) state_d = WAIT_LOCK;
            WAIT_LOCK:   if (lock_s) state_d = LOCK_STABLE;
            LOCK_STABLE: begin
                if (!lock_s)                 state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = PERIPH_ON;
            end
            PERIPH_ON:   if (cnt_q == CORE_LAST) state_d = RUN;
            RUN: begin
                if (sw_rst_req) begin
                    state_d = SW_RST;
                    cause_d = CAUSE_SW;
                end
            end
            SW_RST:      if (cnt_q == SW_LAST) state_d = PERIPH_ON;
            default:     state_d = HOLD;
        endcase

        // Lock loss overrides anything decided above, including a same-cycle sw request.
        if (lock_lost) begin
            state_d = WAIT_LOCK;
            cause_d = CAUSE_LOCK;
            if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
        end

        cnt_d          = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        rst_periph_n_d = (state_d == PERIPH_ON) || (state_d == RUN);
        rst_core_n_d   = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q        <= HOLD;
            rst_sync_q     <= '0;
            lock_sync_q    <= '0;
            cnt_q          <= '0;
            cause_q        <= 2'b00;
            loss_cnt_q     <= 8'd0;
            rst_periph_n_q <= 1'b0;
            rst_core_n_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_sync_q     <= rst_sync_d;
            lock_sync_q    <= lock_sync_d;
            cnt_q          <= cnt_d;
            cause_q        <= cause_d;
            loss_cnt_q     <= loss_cnt_d;
            rst_periph_n_q <= rst_periph_n_d;
            rst_core_n_q   <= rst_core_n_d;
        end
    end

    assign rst_periph_n  = rst_periph_n_q;
    assign rst_core_n    = rst_core_n_q;
    assign rst_state     = state_q;
    assign rst_cause     = cause_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timeline vector table, hand-built corner sequences, and a
// randomized run compared every cycle against a behavioural model of the sequencing rules.
module tb_rst_sequencer;

    localparam int SYNC     = 2;
    localparam int LOCK_CYC = 8;
    localparam int CORE_CYC = 4;
    localparam int SW_CYC   = 6;

    logic       clk_sys = 1'b0;
    logic       rst_sys_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       rst_periph_n, rst_core_n;
    logic [2:0] rst_state;
    logic [1:0] rst_cause;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rst_sequencer #(
        .SYNC_STAGES    (SYNC),
        .LOCK_STABLE_CYC(LOCK_CYC),
        .CORE_DELAY     (CORE_CYC),
        .SW_RST_CYC     (SW_CYC)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .rst_periph_n (rst_periph_n),
        .rst_core_n   (rst_core_n),
        .rst_state    (rst_state),
        .rst_cause    (rst_cause),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: the synchronisers are modelled as an edge count since release
    // and a delay queue of lock samples; timed phases count down the cycles remaining.
    int         m_phase, m_left, m_losses, m_rel;
    logic [1:0] m_cause;
    logic       m_pll_q[$];
    logic       m_rs, m_ls;

    always @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            m_phase = 0; m_left = 0; m_losses = 0; m_rel = 0; m_cause = 2'b00;
            m_pll_q.delete();
            for (int i = 0; i < SYNC; i++) m_pll_q.push_back(1'b0);
        end else begin
            m_rs = (m_rel >= SYNC);
            if (m_rel < SYNC) m_rel++;
            m_ls = m_pll_q.pop_front();
            m_pll_q.push_back(pll_locked);
            if ((m_phase >= 3) && !m_ls) begin
                m_phase = 1;
                m_cause = 2'b01;
                if (m_losses < 255) m_losses++;
            end else begin
                case (m_phase)
                    0: if (m_rs) m_phase = 1;
                    1: if (m_ls) begin m_phase = 2; m_left = LOCK_CYC; end
                    2: if (!m_ls) m_phase = 1;
                       else begin
                           m_left--;
                           if (m_left == 0) begin m_phase = 3; m_left = CORE_CYC; end
                       end
                    3: begin
                           m_left--;
                           if (m_left == 0) m_phase = 4;
                       end
                    4: if (sw_rst_req) begin m_phase = 5; m_left = SW_CYC; m_cause = 2'b10; end
                    5: begin
                           m_left--;
                           if (m_left == 0) begin m_phase = 3; m_left = CORE_CYC; end
                       end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    always @(negedge clk_sys) begin
        logic [2:0] exp_st;
        logic [7:0] exp_cnt;
        logic       exp_p, exp_c;
        exp_st  = m_phase[2:0];
        exp_cnt = m_losses[7:0];
        exp_p   = (m_phase == 3) || (m_phase == 4);
        exp_c   = (m_phase == 4);
        check("model {periph,core,state,cause,cnt}",
              {17'd0, rst_periph_n, rst_core_n, rst_state, rst_cause, lock_loss_cnt},
              {17'd0, exp_p, exp_c, exp_st, m_cause, exp_cnt});
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input logic pll);
        rst_sys_n  = 1'b0;
        pll_locked = pll;
        sw_rst_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #3 rst_sys_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (rst_state !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, rst_state, s);
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    typedef struct {
        int         cyc;
        logic       pll;
        logic       sw;
        logic [2:0] st;
        logic       p;
        logic       c;
        logic [1:0] cause;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Timeline from reset release; cyc is the number of edges to advance.
        vecs.push_back('{2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 8'd0}); // edge 2
        vecs.push_back('{1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0, 8'd0}); // 3
        vecs.push_back('{1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 8'd0}); // 4
        vecs.push_back('{7, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 2'd0, 8'd0}); // 11
        vecs.push_back('{1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 8'd0}); // 12
        vecs.push_back('{3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 8'd0}); // 15
        vecs.push_back('{1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 2'd0, 8'd0}); // 16
        vecs.push_back('{1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 2'd2, 8'd0}); // 17 sw reset
        vecs.push_back('{5, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 2'd2, 8'd0}); // 22
        vecs.push_back('{1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd2, 8'd0}); // 23
        vecs.push_back('{1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 2'd2, 8'd0}); // 24 sw ignored
        vecs.push_back('{2, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd2, 8'd0}); // 26
        vecs.push_back('{1, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 2'd2, 8'd0}); // 27
        vecs.push_back('{2, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 2'd2, 8'd0}); // 29 lock dropped
        vecs.push_back('{1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd1, 8'd1}); // 30 lock loss
        vecs.push_back('{2, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd1, 8'd1}); // 32
        vecs.push_back('{2, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 2'd1, 8'd1}); // 34 relocking
        vecs.push_back('{1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 2'd1, 8'd1}); // 35
        vecs.push_back('{8, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1, 8'd1}); // 43
        vecs.push_back('{4, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 2'd1, 8'd1}); // 47

        #2;
        check("reset periph", rst_periph_n, 1'b0);
        check("reset core", rst_core_n, 1'b0);
        check("reset state", rst_state, 3'd0);
        check("reset cause", rst_cause, 2'd0);
        check("reset count", lock_loss_cnt, 8'd0);

        do_reset(1'b1);
        foreach (vecs[i]) begin
            pll_locked = vecs[i].pll;
            sw_rst_req = vecs[i].sw;
            repeat (vecs[i].cyc) tick();
            sw_rst_req = 1'b0;
            check($sformatf("vec%0d state", i), rst_state, vecs[i].st);
            check($sformatf("vec%0d periph", i), rst_periph_n, vecs[i].p);
            check($sformatf("vec%0d core", i), rst_core_n, vecs[i].c);
            check($sformatf("vec%0d cause", i), rst_cause, vecs[i].cause);
            check($sformatf("vec%0d count", i), lock_loss_cnt, vecs[i].cnt);
        end

        // Software request and lock loss in the same cycle: lock loss wins.
        sw_pulse();
        check("sw state", rst_state, 3'd5);
        check("sw cause", rst_cause, 2'd2);
        wait_state(3'd4, 40, "sw back to run");
        pll_locked = 1'b0;
        tick();
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check("race state", rst_state, 3'd1);
        check("race cause", rst_cause, 2'd1);
        check("race count", lock_loss_cnt, 8'd2);

        // Lock glitch while LOCK_STABLE counter is at 5: the full stable wait restarts.
        do_reset(1'b1);
        repeat (9) tick();
        check("glitch pre state", rst_state, 3'd2);
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        check("glitch drop state", rst_state, 3'd1);
        check("glitch drop count", lock_loss_cnt, 8'd0);
        check("glitch drop cause", rst_cause, 2'd0);
        repeat (3) tick();
        check("glitch relock state", rst_state, 3'd2);
        repeat (7) tick();
        check("glitch still waiting", rst_state, 3'd2);
        check("glitch periph low", rst_periph_n, 1'b0);
        tick();
        check("glitch periph on", rst_state, 3'd3);
        check("glitch periph high", rst_periph_n, 1'b1);
        check("glitch count", lock_loss_cnt, 8'd0);

        // 300 lock-loss events saturate the counter at 255.
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b1;
            wait_state(3'd4, 60, "relock to run");
            pll_locked = 1'b0;
            wait_state(3'd1, 10, "lock loss to wait");
            if (k == 0) check("first loss count", lock_loss_cnt, 8'd1);
        end
        pll_locked = 1'b1;
        wait_state(3'd4, 60, "final relock");
        check("saturated count", lock_loss_cnt, 8'd255);
        check("saturated cause", rst_cause, 2'd1);

        // Async board reset in PERIPH_ON clears everything without a clock edge.
        sw_pulse();
        check("sw2 cause", rst_cause, 2'd2);
        wait_state(3'd3, 20, "sw2 to periph_on");
        @(posedge clk_sys);
        #3 rst_sys_n = 1'b0;
        #1;
        check("async periph", rst_periph_n, 1'b0);
        check("async core", rst_core_n, 1'b0);
        check("async state", rst_state, 3'd0);
        check("async cause", rst_cause, 2'd0);
        check("async count", lock_loss_cnt, 8'd0);
        #10 rst_sys_n = 1'b1;

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                pll_locked = 1'b1;
            end
            sw_rst_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 699) == 0) begin
                rst_sys_n = 1'b0;
                #2 rst_sys_n = 1'b1;
            end
            tick();
        end
        sw_rst_req = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
